mult_seq_controller: RTL and testbench
======================================

Name: mult_seq_controller

Overview:
- Moore/Mealy control FSM that sequences the shift-add multiplier datapath.
- Datapath: 64-bit product register with preset, 32-bit multiplicand register, 32-bit adder on the product upper half.
- Per operation: loads operands, runs one add/shift iteration per clock for WIDTH clocks, then reports completion.
- Sits between the MIPS MULT/MULTU issue logic and the multiplier datapath. Owns Busy/Done toward the pipeline.

Parameters:
- WIDTH, 32, operand width; iteration count per operation.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- Abort  input  1  synchronous cancel; returns to IDLE from any state.
- Signed_Op  input  1  1 = MULT (signed), 0 = MULTU.
- Prod_Lsb  input  1  product register bit 0 (current multiplier bit).
- Mcand_Load  output  1  load enable for the multiplicand register.
- Prod_Preset  output  1  drives product register preset/load: {0, multiplier} into the product register.
- Prod_En  output  1  product register write enable (one shift step).
- Add_En  output  1  1 = upper half takes adder sum before shift; 0 = pass-through.
- Sub_En  output  1  adder performs subtract (signed correction).
- Arith_Shift  output  1  shift-in bit is sign of upper half instead of carry.
- Iter  output  CNT_W  remaining iterations (debug/trace).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse; product register valid.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- Reset low (any time, asynchronous):
  - state = IDLE, Iter = 0.
  - All outputs 0.
  - Product register contents are not touched by this block.
- IDLE:
  - All control outputs 0, Busy = 0.
  - Start = 1 -> LOAD.
  - Signed_Op is latched into an internal Sgn bit on the same edge.
- LOAD (exactly 1 cycle):
  - Mcand_Load = 1, Prod_Preset = 1, Busy = 1, Prod_En = 0.
  - Iter loaded with WIDTH-1 on exit.
  - Next state: RUN.
- RUN (exactly WIDTH cycles):
  - Prod_En = 1, Busy = 1.
  - Add_En = Prod_Lsb (combinational, same cycle).
  - Iter decrements by 1 each cycle.
  - When Iter == 0 in RUN, this is the last step; next state is DONE.
- DONE (1 cycle):
  - Done = 1, Busy = 0, all datapath enables 0.
  - Next state: IDLE.
  - Product register holds the result until the next LOAD.
- Latency: Start sampled at edge N -> Done high during cycle N+WIDTH+2 (34 cycles for WIDTH = 32).
- Start while Busy or in DONE: ignored; no queuing.
- Abort:
  - Has priority over all transitions; next state is IDLE, Iter = 0, no Done pulse.
  - Abort and Start in the same IDLE cycle: remain in IDLE.
- Iter never wraps; it holds 0 outside RUN.
- Sub_En and Arith_Shift are 0 except as defined under Optional Feature.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - Arith_Shift = Sgn throughout RUN.
  - On the last RUN step (Iter == 0), if Sgn = 1 and Prod_Lsb = 1, then Sub_En = 1 and Add_En = 1. This is the two's-complement multiplier sign-bit correction.
  - Result is a correct signed 64-bit product.
- Not defined:
  - Sub_En and Arith_Shift are tied 0.
  - Signed_Op is ignored (Sgn is not implemented).
  - Every operation is unsigned.

Test Plan:
- Reset low mid-RUN (Iter = 17) -> within the same cycle, Busy = 0, Prod_En = 0, Iter = 0. After release, idle until Start.
- WIDTH = 32, Start pulse at cycle 0 ->
  - LOAD at cycle 1 (Mcand_Load = Prod_Preset = 1).
  - Prod_En high for cycles 2..33.
  - Done pulse at cycle 34; Busy high for cycles 1..33 only.
- Datapath model, MULTU 0x00000003 x 0x00000005 -> Add_En high only on steps where Prod_Lsb = 1 (steps 0 and 2). Product = 0x000000000000000F at Done.
- Start held high for 40 cycles -> exactly one operation.
  - Second LOAD occurs the cycle after returning to IDLE (cycle 36).
  - No Start is accepted during cycles 1..34.
- Abort at RUN step 10 -> IDLE next cycle, no Done. A new Start then completes normally with the full 34-cycle latency.
- With MULT_SIGNED_EN, MULT 0xFFFFFFFF (-1) x 0x00000007 -> Sub_En high on the last step only. Product = 0xFFFFFFFFFFFFFFF9.
- Without the macro, same stimulus -> Sub_En never high. Product = 0x00000006FFFFFFF9.

Source files
------------

// File: rtl/mult_seq_controller.sv
// rtl/mult_seq_controller.sv - control FSM sequencing a shift-add 32x32 multiplier datapath.
// Optional signed (MULT) support via `define MULT_SIGNED_EN; default build is unsigned only.
module mult_seq_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_signed_op,
  input  logic             i_prod_lsb,
  output logic             o_mcand_load,
  output logic             o_prod_preset,
  output logic             o_prod_en,
  output logic             o_add_en,
  output logic             o_sub_en,
  output logic             o_arith_shift,
  output logic [CNT_W-1:0] o_iter,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ITER_FIRST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] w_iter_next;
  logic             w_run;
  logic             w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      r_iter  <= w_iter_next;
    end
  end

  // Abort overrides every transition, including a Start seen in IDLE.
  always_comb begin
    w_next      = r_state;
    w_iter_next = r_iter;
    case (r_state)
      S_IDLE: begin
        w_iter_next = '0;
        if (i_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next      = S_RUN;
        w_iter_next = ITER_FIRST;
      end
      S_RUN: begin
        if (r_iter == '0) w_next = S_DONE;
        else              w_iter_next = r_iter - 1'b1;
      end
      S_DONE: begin
        w_next      = S_IDLE;
        w_iter_next = '0;
      end
      default: begin
        w_next      = S_IDLE;
        w_iter_next = '0;
      end
    endcase
    if (i_abort) begin
      w_next      = S_IDLE;
      w_iter_next = '0;
    end
  end

  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_iter == '0);

  always_comb begin
    o_mcand_load  = (r_state == S_LOAD);
    o_prod_preset = (r_state == S_LOAD);
    o_prod_en     = w_run;
    o_add_en      = w_run && i_prod_lsb;
    o_busy        = (r_state == S_LOAD) || w_run;
    o_done        = (r_state == S_DONE);
    o_iter        = r_iter;
  end

`ifdef MULT_SIGNED_EN
  logic r_sgn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           r_sgn <= 1'b0;
    else if (r_state == S_IDLE && i_start)  r_sgn <= i_signed_op;
  end

  // Multiplier sign bit has weight -2^(WIDTH-1): the final step subtracts.
  assign o_arith_shift = w_run && r_sgn;
  assign o_sub_en      = w_last && r_sgn && i_prod_lsb;
`else
  logic w_unused_signed_op;
  logic w_unused_last;

  assign w_unused_signed_op = i_signed_op;
  assign w_unused_last      = w_last;
  assign o_arith_shift      = 1'b0;
  assign o_sub_en           = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_controller.sv
// tb/tb_mult_seq_controller.sv - scoreboard bench for mult_seq_controller with a datapath model.
module tb_mult_seq_controller;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        signed_op = 1'b0;
  logic        prod_lsb;
  logic        o_mcand_load, o_prod_preset, o_prod_en, o_add_en, o_sub_en, o_arith_shift;
  logic [5:0]  o_iter;
  logic        o_busy, o_done;

  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic [63:0] prod = '0;
  logic [31:0] mcand = '0;
  logic [31:0] up;
  logic [32:0] sum33;

  typedef struct {
    int          c;
    logic [63:0] exp;
    bit          sgn;
  } op_t;

  op_t q[$];
  int  cyc = 0;
  int  free_c = 0;
  int  checks = 0;
  int  errors = 0;

  mult_seq_controller #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_signed_op  (signed_op),
    .i_prod_lsb   (prod_lsb),
    .o_mcand_load (o_mcand_load),
    .o_prod_preset(o_prod_preset),
    .o_prod_en    (o_prod_en),
    .o_add_en     (o_add_en),
    .o_sub_en     (o_sub_en),
    .o_arith_shift(o_arith_shift),
    .o_iter       (o_iter),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign prod_lsb = prod[0];

  // Product/multiplicand registers and 33-bit adder driven by the DUT controls.
  always @(posedge clk) begin
    if (o_prod_preset) begin
      prod  <= {32'b0, b_drv};
      mcand <= a_drv;
    end else if (o_prod_en) begin
      up = prod[63:32];
      if (o_arith_shift) begin
        if (o_add_en) sum33 = o_sub_en ? ({up[31], up} - {mcand[31], mcand})
                                       : ({up[31], up} + {mcand[31], mcand});
        else          sum33 = {up[31], up};
      end else begin
        if (o_add_en) sum33 = o_sub_en ? ({1'b0, up} - {1'b0, mcand})
                                       : ({1'b0, up} + {1'b0, mcand});
        else          sum33 = {1'b0, up};
      end
      prod <= {sum33[32], sum33[31:0], prod[31:1]};
    end
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    if (SIGNED_BUILD && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: expected control timing derived from the start cycle of the pending operation.
  always @(negedge clk) begin
    bit has, run, sg;
    int c;
    has = (q.size() > 0);
    c   = has ? q[0].c : -1000;
    sg  = has ? q[0].sgn : 1'b0;
    run = has && (cyc >= c + 2) && (cyc <= c + 33);
    chk("busy",        64'(o_busy),        64'(has && cyc >= c + 1 && cyc <= c + 33));
    chk("mcand_load",  64'(o_mcand_load),  64'(has && cyc == c + 1));
    chk("prod_preset", 64'(o_prod_preset), 64'(has && cyc == c + 1));
    chk("prod_en",     64'(o_prod_en),     64'(run));
    chk("iter",        64'(o_iter),        run ? 64'(c + 33 - cyc) : 64'd0);
    chk("add_en",      64'(o_add_en),      64'(run && prod[0]));
    chk("sub_en",      64'(o_sub_en),      64'(run && SIGNED_BUILD && sg && cyc == c + 33 && prod[0]));
    chk("arith_shift", 64'(o_arith_shift), 64'(run && SIGNED_BUILD && sg));
    chk("done",        64'(o_done),        64'(has && cyc == c + 34));
    if (has && cyc == c + 34) begin
      chk("product", prod, q[0].exp);
      void'(q.pop_front());
    end
  end

  task automatic step(input bit s, input bit ab, input bit sg, input logic [31:0] a, input logic [31:0] b);
    int  c;
    op_t e;
    c = cyc;
    start = s;
    abort = ab;
    signed_op = sg;
    if (s && !ab && c >= free_c) begin
      a_drv = a;
      b_drv = b;
      e.c   = c;
      e.exp = ref_mul(a, b, sg);
      e.sgn = sg;
      q.push_back(e);
      free_c = c + 35;
    end
    @(posedge clk);
    #1;
    if (ab) begin
      q.delete();
      free_c = cyc;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    64'(o_busy),    64'd0);
    chk("rst_done",    64'(o_done),    64'd0);
    chk("rst_prod_en", 64'(o_prod_en), 64'd0);
    chk("rst_iter",    64'(o_iter),    64'd0);
    rst_n = 1'b1;
    free_c = cyc;
    idle(2);

    step(1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005);
    idle(40);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF);
    idle(40);

    // Start held for 40 cycles: one op, then a second LOAD right after IDLE.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    idle(40);

    step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    idle(11);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0001);
    idle(40);

    step(1'b1, 1'b1, 1'b0, 32'd9, 32'd9);
    idle(3);

    step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    c0 = cyc - 1;
    while (cyc < c0 + 16) idle(1);
    #1;
    chk("pre_reset_iter", 64'(o_iter), 64'd17);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_busy",    64'(o_busy),    64'd0);
    chk("async_rst_prod_en", 64'(o_prod_en), 64'd0);
    chk("async_rst_iter",    64'(o_iter),    64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    free_c = cyc;
    idle(5);

    for (int i = 0; i < 1500; i++)
      step(($urandom % 6) == 0, ($urandom % 80) == 0, 1'($urandom % 2), $urandom, $urandom);

    for (int k = 0; k < 100 && q.size() > 0; k++) idle(1);
    chk("drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
